// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32IM multiply/divide unit with fixed 33-edge latency
module mul_div_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;      // mul: {partial hi, multiplier lo}; div: {remainder, quotient}
  logic [31:0] b_mag_q, b_mag_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  // operand decode at acceptance
  logic        a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic [31:0] a_mag_in, b_mag_in;

  // iteration and finish datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] prod_signed;
  logic [31:0] quo_signed, rem_signed, result_sel;
  logic        div_by_zero;

  // Decode signedness and operand magnitudes from the live inputs
  always_comb begin
    a_signed_in = (FUNCT3 == OP_MULH) || (FUNCT3 == OP_MULHSU) ||
                  (FUNCT3 == OP_DIV)  || (FUNCT3 == OP_REM);
    b_signed_in = (FUNCT3 == OP_MULH) || (FUNCT3 == OP_DIV) || (FUNCT3 == OP_REM);
    a_neg_in    = a_signed_in && DATA1[31];
    b_neg_in    = b_signed_in && DATA2[31];
    // 0x80000000 negates to itself, which read unsigned is exactly 2^31
    a_mag_in    = a_neg_in ? (~DATA1 + 32'd1) : DATA1;
    b_mag_in    = b_neg_in ? (~DATA2 + 32'd1) : DATA2;
  end

  // One shift-add multiply step and one restoring divide step on the accumulator
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_mag_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = acc_q[63:31];
    div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
    div_next  = div_diff[33] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
  end

  // Sign correction and result selection for the FINISH state
  always_comb begin
    prod_signed = (a_neg_q ^ b_neg_q) ? (~acc_q + 64'd1) : acc_q;
    quo_signed  = (a_neg_q ^ b_neg_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    // With a zero divisor every trial subtract succeeds, so the remainder ends up
    // equal to the dividend magnitude and re-signing it yields DATA1 unchanged.
    rem_signed  = a_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    div_by_zero = (b_mag_q == 32'd0);
    result_sel  = 32'd0;
    case (op_q)
      OP_MUL:                     result_sel = prod_signed[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_sel = prod_signed[63:32];
      OP_DIV, OP_DIVU:            result_sel = div_by_zero ? 32'hFFFF_FFFF : quo_signed;
      OP_REM, OP_REMU:            result_sel = rem_signed;
      default:                    result_sel = 32'd0;
    endcase
  end

  // State register and datapath flops
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      acc_q    <= 64'd0;
      b_mag_q  <= 32'd0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      cnt_q    <= 5'd0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      b_mag_q  <= b_mag_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Next-state: accept in IDLE, 32 iterations in CALC, one FINISH edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (START) state_d = S_CALC;
      S_CALC:   if (cnt_q == 5'd31) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch operands, iterate, then register the result
  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    b_mag_d  = b_mag_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d    = FUNCT3;
          acc_d   = {32'd0, a_mag_in};
          b_mag_d = b_mag_in;
          a_neg_d = a_neg_in;
          b_neg_d = b_neg_in;
          cnt_d   = 5'd0;
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
      end
      S_FINISH: begin
        result_d = result_sel;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs: BUSY from state, DONE and RESULT straight from flops
  always_comb begin
    BUSY   = (state_q != S_IDLE);
    DONE   = done_q;
    RESULT = result_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  int   busy_run = 0;

  mul_div_unit dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .FUNCT3 (FUNCT3),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .RESULT (RESULT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  // Monitor: pop one expectation per DONE pulse, check value, latency and busy length
  always @(negedge CLK) begin
    if (DONE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE at edge %0d expected none", edge_cnt);
      end else begin
        mon_e = sb.pop_front();
        chk("result", RESULT, mon_e.res);
        chk("latency_edge", 32'(edge_cnt), 32'(mon_e.due));
        chk("busy_cycles", 32'(busy_run), 32'd33);
      end
      busy_run = 0;
    end else if (BUSY) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  // Called at a negedge with the unit idle (or in its DONE cycle)
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r);
    START  = 1'b1;
    FUNCT3 = f;
    DATA1  = a;
    DATA2  = b;
    sb.push_back('{exp_r, edge_cnt + 34});
    @(negedge CLK);
    START  = 1'b0;
    FUNCT3 = 3'($urandom);
    DATA1  = $urandom;
    DATA2  = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!DONE && n < 60) begin
      @(negedge CLK);
      n++;
    end
    if (!DONE) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE after %0d cycles expected DONE", n);
    end
  endtask

  initial begin
    RESET  = 1'b1;
    START  = 1'b0;
    FUNCT3 = 3'd0;
    DATA1  = 32'd0;
    DATA2  = 32'd0;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_busy",   {31'd0, BUSY}, 32'd0);
    chk("reset_done",   {31'd0, DONE}, 32'd0);
    chk("reset_result", RESULT,        32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    issue(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB); wait_done();
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_done();
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_done();
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD); wait_done();
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF); wait_done();
    issue(3'b101, 32'd100,       32'd7,         32'd14);        wait_done();
    issue(3'b111, 32'd100,       32'd7,         32'd2);         wait_done();
    issue(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF); wait_done();
    issue(3'b111, 32'd5,         32'd0,         32'd5);         wait_done();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);         wait_done();

    // START pulsed mid-operation with other operands is ignored
    issue(3'b101, 32'd100, 32'd7, 32'd14);
    repeat (9) @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'b101; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(negedge CLK);
    START = 1'b0;
    wait_done();

    // START held from mid-operation through DONE launches the next op
    issue(3'b101, 32'd100, 32'd7, 32'd14);
    repeat (9) @(negedge CLK);
    START = 1'b1; FUNCT3 = 3'b111; DATA1 = 32'd100; DATA2 = 32'd7;
    wait_done();
    sb.push_back('{32'd2, edge_cnt + 34});
    @(negedge CLK);
    START = 1'b0; DATA1 = $urandom; DATA2 = $urandom;
    wait_done();

    // Reset mid-MUL aborts it, then a fresh op completes normally
    issue(3'b000, 32'h0001_2345, 32'h0000_0777, 32'h0000_0000);
    repeat (14) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    sb.delete();
    chk("abort_busy",   {31'd0, BUSY}, 32'd0);
    chk("abort_done",   {31'd0, DONE}, 32'd0);
    chk("abort_result", RESULT,        32'd0);
    RESET = 1'b0;
    issue(3'b000, 32'd7, 32'd3, 32'd21);
    wait_done();

    repeat (40) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the RV32IM M-extension.
- Sits in the execute stage, directly downstream of the register file. Its operands are the two register-file read ports.
- Runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over a fixed number of cycles.
- The pipeline stalls while BUSY is high. RESULT goes to the writeback path and back into the register file's write port.

Parameters:
- None. The datapath is fixed at 32 bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request strobe; sampled only in IDLE.
- FUNCT3  input  3  RISC-V M-extension funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- DATA1  input  32  rs1 operand (register file OUT1).
- DATA2  input  32  rs2 operand (register file OUT2).
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  single-cycle pulse; RESULT is valid.
- RESULT  output  32  operation result; registered.

Behaviour:
- Reset: RESET=1 at a rising edge drives:
  - state to IDLE
  - BUSY=0, DONE=0, RESULT=0
  - all internal accumulators, counters and sign flags to 0
- Reset wins over every other input. Reset mid-operation aborts it: no DONE pulse, RESULT=0.
- States: IDLE, CALC, FINISH.
- IDLE:
  - START=1 at edge N latches FUNCT3, DATA1, DATA2 and the operand signs, then moves to CALC.
  - BUSY=1 from after edge N.
  - START=0 stays in IDLE.
- CALC:
  - Exactly 32 iterations, one per edge, counted by a 5-bit counter. Runs at edges N+1..N+32.
  - Multiply: radix-2 shift-add on operand magnitudes into a 64-bit product.
  - Divide: restoring division on magnitudes, producing a 32-bit quotient and a 32-bit remainder.
  - After the 32nd iteration, move to FINISH.
- FINISH (edge N+33):
  - Apply sign correction, select the result and register RESULT.
  - DONE=1 and BUSY=0 for exactly the cycle after edge N+33.
  - State returns to IDLE.
- Fixed latency: DONE is visible 33 edges after START is accepted, for every op, including the special cases below.
- Back-to-back: START high during the DONE cycle is accepted at the next edge (N+34).
- START while BUSY=1 is ignored; the in-flight operation and its latched operands are unaffected.
- DATA1/DATA2/FUNCT3 may change after acceptance without effect.
- RESULT holds its value until the next FINISH or RESET. DONE=0 in all other cycles.
- Signedness:
  - MULH and DIV/REM: both operands signed.
  - MULHSU: DATA1 signed, DATA2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: low 32 bits; identical for all signedness.
- Negate the product if the operand signs differ (signed operands only).
- Quotient sign = sign(DATA1) XOR sign(DATA2). Remainder sign = sign(DATA1).
- Product select: MUL takes bits [31:0]; MULH/MULHSU/MULHU take bits [63:32].
- Divide by zero (DATA2=0):
  - DIV/DIVU give 0xFFFFFFFF.
  - REM/REMU give DATA1.
- Signed overflow (DIV/REM, DATA1=0x80000000, DATA2=0xFFFFFFFF):
  - DIV gives 0x80000000.
  - REM gives 0x00000000.
- Magnitude of 0x80000000 is handled as unsigned 2^31; no 33-bit operand is needed.

Test Plan:
- RESET high for 2 edges, then START MUL with 7 × 0xFFFFFFFD:
  - BUSY=1 for 33 cycles.
  - DONE pulses once, 33 edges after acceptance.
  - RESULT=0xFFFFFFEB.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU of the same → 2.
- Special cases, each with unchanged 33-edge latency:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- START pulsed at cycle 10 of a running DIVU with different operands:
  - Ignored; the original result is delivered on schedule.
  - START held through the DONE cycle launches the next op at the following edge, DONE 33 edges later.
- RESET asserted at cycle 15 of a MUL:
  - Next cycle shows BUSY=0, DONE=0, RESULT=0.
  - No DONE ever appears for the aborted op.
  - A fresh START right after reset completes normally.
